// File: rtl/hk_spi_arbiter_if.sv
// Requester-side and SPI-master-side signals of the housekeeping SPI arbiter.
// The slave modport is the arbiter's view; master is the surrounding block's view.
interface hk_spi_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_i;
  logic [NREQ*16-1:0] wr_h_i;
  logic [NREQ*16-1:0] wr_l_i;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    done_o;
  logic               err_o;
  logic [15:0]        rd_o;
  logic               err_sts_o;
  logic               err_clr_i;
  logic               spi_start_o;
  logic [15:0]        spi_wr_h_o;
  logic [15:0]        spi_wr_l_o;
  logic [15:0]        spi_rd_l_i;
  logic               spi_busy_i;

  modport slave (
    input  req_i, wr_h_i, wr_l_i, err_clr_i, spi_rd_l_i, spi_busy_i,
    output gnt_o, done_o, err_o, rd_o, err_sts_o, spi_start_o, spi_wr_h_o, spi_wr_l_o
  );

  modport master (
    output req_i, wr_h_i, wr_l_i, err_clr_i, spi_rd_l_i, spi_busy_i,
    input  gnt_o, done_o, err_o, rd_o, err_sts_o, spi_start_o, spi_wr_h_o, spi_wr_l_o
  );
endinterface

// File: rtl/hk_spi_arbiter.sv
// Round-robin arbiter sharing one housekeeping SPI master between NREQ requesters,
// with busy-rise and transfer timeouts and a done/error handshake per transaction.
module hk_spi_arbiter #(
  parameter int NREQ     = 2,
  parameter int BSY_TMO  = 16,
  parameter int XFER_TMO = 16384,
  parameter int TW       = 15
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  hk_spi_arbiter_if.slave   bus
);

  localparam int            PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TW-1:0] BSY_LAST  = TW'(BSY_TMO - 1);
  localparam logic [TW-1:0] XFER_LAST = TW'(XFER_TMO - 1);
  localparam logic [PW-1:0] PTR_RST   = PW'(NREQ - 1);

  typedef enum logic [2:0] {IDLE, START, WBSY, WXFER, DONE} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, win, cand;
  logic [NREQ-1:0] mask_q, elig, win_oh, gnt_q, done_q;
  logic            found, grant, fin, tmo;
  logic            start_q, err_q, err_sts_q;
  logic [15:0]     rd_q, wr_h_q, wr_l_q;

  // Search upward from the requester after the last winner, wrapping to 0.
  always_comb begin
    elig   = bus.req_i & ~mask_q;
    found  = 1'b0;
    win    = ptr_q;
    cand   = '0;
    win_oh = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_oh[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    fin     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        // An aborted transfer leaves the SPI master running; hold off until it idles.
        if (found && !bus.spi_busy_i) begin
          grant   = 1'b1;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WBSY;
      end
      WBSY: begin
        if (bus.spi_busy_i) begin
          cnt_d   = '0;
          state_d = WXFER;
        end else if (cnt_q == BSY_LAST) begin
          fin     = 1'b1;
          tmo     = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      WXFER: begin
        if (!bus.spi_busy_i) begin
          fin     = 1'b1;
          state_d = DONE;
        end else if (cnt_q == XFER_LAST) begin
          fin     = 1'b1;
          tmo     = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs are registered on the edge entering DONE so they coincide with it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q     <= PTR_RST;
      mask_q    <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      err_sts_q <= 1'b0;
      start_q   <= 1'b0;
      rd_q      <= '0;
      wr_h_q    <= '0;
      wr_l_q    <= '0;
    end else begin
      start_q <= (state_q == START);
      done_q  <= fin ? gnt_q : '0;
      err_q   <= fin & tmo;
      if (fin && !tmo) rd_q <= bus.spi_rd_l_i;
      if (fin && tmo) err_sts_q <= 1'b1;
      else if (bus.err_clr_i) err_sts_q <= 1'b0;
      if (state_q == DONE) mask_q <= gnt_q;
      else if (state_q == IDLE) mask_q <= '0;
      if (grant) begin
        gnt_q  <= win_oh;
        ptr_q  <= win;
        wr_h_q <= bus.wr_h_i[16*win +: 16];
        wr_l_q <= bus.wr_l_i[16*win +: 16];
      end else if (state_q == DONE) begin
        gnt_q <= '0;
      end
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.rd_o        = rd_q;
  assign bus.err_sts_o   = err_sts_q;
  assign bus.spi_start_o = start_q;
  assign bus.spi_wr_h_o  = wr_h_q;
  assign bus.spi_wr_l_o  = wr_l_q;

endmodule

// File: tb/tb_hk_spi_arbiter.sv
// Directed bench for hk_spi_arbiter: two requesters, behavioural SPI master busy model.
module tb_hk_spi_arbiter;

  logic clk;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;

  int   cyc = 0;
  int   start_cnt = 0, done_cnt = 0;
  int   last_start_cyc = 0, last_done_cyc = 0;
  logic [1:0] last_done;
  logic       last_err;

  int   mdl_mode = 0;  // 0 normal, 1 busy never rises, 2 busy stuck high
  int   mdl_dly  = 2;
  int   mdl_len  = 50;

  hk_spi_arbiter_if #(.NREQ(2)) bus ();

  hk_spi_arbiter #(.NREQ(2), .BSY_TMO(16), .XFER_TMO(64), .TW(15)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts start-pulse cycles and done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.spi_start_o) begin start_cnt++; last_start_cyc = cyc; end
      if (bus.done_o != 2'b00) begin
        done_cnt++;
        last_done     = bus.done_o;
        last_err      = bus.err_o;
        last_done_cyc = cyc;
      end
    end
  end

  // SPI master busy model.
  initial begin
    bus.spi_busy_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.spi_start_o) begin
        if (mdl_mode == 0) begin
          repeat (mdl_dly) @(posedge clk);
          #1; bus.spi_busy_i = 1'b1;
          repeat (mdl_len) @(posedge clk);
          #1; bus.spi_busy_i = 1'b0;
        end else if (mdl_mode == 2) begin
          #1; bus.spi_busy_i = 1'b1;
          while (mdl_mode == 2) @(posedge clk);
          #1; bus.spi_busy_i = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input int target, input int limit, output bit ok);
    int n = 0;
    while (n < limit && done_cnt < target) begin
      @(negedge clk); #1;
      n++;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic apply_reset();
    @(negedge clk); rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.gnt_o !== 2'b00) begin failures++; $display("FAIL rst_gnt got=%b exp=00", bus.gnt_o); end
    checks++; if (bus.spi_start_o !== 1'b0 || bus.done_o !== 2'b00 || bus.err_o !== 1'b0) begin
      failures++; $display("FAIL rst_ctl got start=%b done=%b err=%b exp 0", bus.spi_start_o, bus.done_o, bus.err_o); end
    checks++; if (bus.rd_o !== 16'h0000 || bus.err_sts_o !== 1'b0) begin
      failures++; $display("FAIL rst_data got rd=%h sts=%b exp 0000/0", bus.rd_o, bus.err_sts_o); end
    checks++; if (bus.spi_wr_h_o !== 16'h0000 || bus.spi_wr_l_o !== 16'h0000) begin
      failures++; $display("FAIL rst_wr got h=%h l=%h exp 0000", bus.spi_wr_h_o, bus.spi_wr_l_o); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.gnt_o !== 2'b00) begin failures++; $display("FAIL rst_idle_gnt got=%b exp=00", bus.gnt_o); end
  endtask

  task automatic test_single();
    bit ok;
    int s0 = start_cnt;
    bus.wr_h_i = {16'h0000, 16'h8012};
    bus.wr_l_i = {16'h0000, 16'h00AA};
    bus.spi_rd_l_i = 16'h005C;
    mdl_mode = 0; mdl_dly = 2; mdl_len = 50;
    @(negedge clk); bus.req_i = 2'b01;
    @(negedge clk);
    checks++; if (bus.gnt_o !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", bus.gnt_o); end
    checks++; if (bus.spi_start_o !== 1'b0) begin failures++; $display("FAIL single_start_early got=%b exp=0", bus.spi_start_o); end
    checks++; if (bus.spi_wr_h_o !== 16'h8012 || bus.spi_wr_l_o !== 16'h00AA) begin
      failures++; $display("FAIL single_words got h=%h l=%h exp 8012/00AA", bus.spi_wr_h_o, bus.spi_wr_l_o); end
    @(negedge clk);
    checks++; if (bus.spi_start_o !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", bus.spi_start_o); end
    @(negedge clk);
    checks++; if (bus.spi_start_o !== 1'b0) begin failures++; $display("FAIL single_start_width got=%b exp=0", bus.spi_start_o); end
    wait_done(done_cnt + 1, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=no_done exp=done"); end
    checks++; if (last_done !== 2'b01 || last_err !== 1'b0) begin
      failures++; $display("FAIL single_done got done=%b err=%b exp 01/0", last_done, last_err); end
    checks++; if (bus.rd_o !== 16'h005C) begin failures++; $display("FAIL single_rd got=%h exp=005C", bus.rd_o); end
    checks++; if (bus.gnt_o !== 2'b01) begin failures++; $display("FAIL single_gnt_at_done got=%b exp=01", bus.gnt_o); end
    bus.req_i = 2'b00;
    @(negedge clk);
    checks++; if (bus.done_o !== 2'b00 || bus.gnt_o !== 2'b00) begin
      failures++; $display("FAIL single_after got done=%b gnt=%b exp 00/00", bus.done_o, bus.gnt_o); end
    checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL single_starts got=%0d exp=1", start_cnt - s0); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    apply_reset();
    bus.wr_h_i = {16'h0002, 16'h8001};
    bus.wr_l_i = {16'h0B02, 16'h0A01};
    bus.spi_rd_l_i = 16'h0077;
    mdl_mode = 0; mdl_dly = 1; mdl_len = 3;
    @(negedge clk); bus.req_i = 2'b11;
    wait_done(done_cnt + 1, 100, ok);
    checks++; if (!ok || last_done !== 2'b01) begin failures++; $display("FAIL sim_first got=%b exp=01", last_done); end
    checks++; if (bus.spi_wr_h_o !== 16'h8001) begin failures++; $display("FAIL sim_first_word got=%h exp=8001", bus.spi_wr_h_o); end
    bus.req_i[0] = 1'b0;
    wait_done(done_cnt + 1, 100, ok);
    checks++; if (!ok || last_done !== 2'b10) begin failures++; $display("FAIL sim_second got=%b exp=10", last_done); end
    checks++; if (bus.spi_wr_l_o !== 16'h0B02) begin failures++; $display("FAIL sim_second_word got=%h exp=0B02", bus.spi_wr_l_o); end
    bus.req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done(done_cnt + 1, 100, ok);
      checks++; if (!ok || last_done !== exp_seq[k]) begin
        failures++; $display("FAIL held_order[%0d] got=%b exp=%b", k, last_done, exp_seq[k]); end
    end
    bus.req_i = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_bsy_timeout();
    bit ok;
    bus.spi_rd_l_i = 16'hDEAD;
    mdl_mode = 1;
    @(negedge clk); bus.req_i = 2'b10;
    wait_done(done_cnt + 1, 100, ok);
    bus.req_i = 2'b00;
    checks++; if (!ok || last_done !== 2'b10 || last_err !== 1'b1) begin
      failures++; $display("FAIL bsy_done got done=%b err=%b exp 10/1", last_done, last_err); end
    checks++; if (last_done_cyc - last_start_cyc !== 16) begin
      failures++; $display("FAIL bsy_latency got=%0d exp=16", last_done_cyc - last_start_cyc); end
    checks++; if (bus.rd_o !== 16'h0077) begin failures++; $display("FAIL bsy_rd_kept got=%h exp=0077", bus.rd_o); end
    repeat (2) @(negedge clk);
    checks++; if (bus.err_sts_o !== 1'b1) begin failures++; $display("FAIL bsy_sticky got=%b exp=1", bus.err_sts_o); end
    bus.err_clr_i = 1'b1;
    @(negedge clk); bus.err_clr_i = 1'b0;
    checks++; if (bus.err_sts_o !== 1'b0) begin failures++; $display("FAIL bsy_clear got=%b exp=0", bus.err_sts_o); end
  endtask

  task automatic test_xfer_timeout();
    bit ok;
    int s0;
    bus.spi_rd_l_i = 16'h1234;
    mdl_mode = 2;
    @(negedge clk); bus.req_i = 2'b11;
    wait_done(done_cnt + 1, 200, ok);
    bus.req_i[0] = 1'b0;
    s0 = start_cnt;
    checks++; if (!ok || last_done !== 2'b01 || last_err !== 1'b1) begin
      failures++; $display("FAIL xfer_abort got done=%b err=%b exp 01/1", last_done, last_err); end
    // One WBSY cycle sees busy rise, then 64 cycles in WXFER.
    checks++; if (last_done_cyc - last_start_cyc !== 65) begin
      failures++; $display("FAIL xfer_latency got=%0d exp=65", last_done_cyc - last_start_cyc); end
    checks++; if (bus.err_sts_o !== 1'b1) begin failures++; $display("FAIL xfer_sticky got=%b exp=1", bus.err_sts_o); end
    repeat (10) @(negedge clk);
    checks++; if (bus.gnt_o !== 2'b00 || start_cnt !== s0) begin
      failures++; $display("FAIL xfer_stall got gnt=%b starts=%0d exp 00/%0d", bus.gnt_o, start_cnt, s0); end
    mdl_mode = 0; mdl_dly = 2; mdl_len = 5;
    wait_done(done_cnt + 1, 100, ok);
    checks++; if (!ok || last_done !== 2'b10 || last_err !== 1'b0) begin
      failures++; $display("FAIL xfer_next got done=%b err=%b exp 10/0", last_done, last_err); end
    checks++; if (bus.rd_o !== 16'h1234) begin failures++; $display("FAIL xfer_next_rd got=%h exp=1234", bus.rd_o); end
    bus.req_i = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_withdraw();
    bit ok;
    int s0 = start_cnt;
    int d0 = done_cnt;
    bus.spi_rd_l_i = 16'h00C3;
    mdl_mode = 0; mdl_dly = 4; mdl_len = 3;
    @(negedge clk); bus.req_i = 2'b01;
    @(negedge clk);
    @(negedge clk); bus.req_i = 2'b00;
    wait_done(d0 + 1, 100, ok);
    checks++; if (!ok || last_done !== 2'b01 || last_err !== 1'b0) begin
      failures++; $display("FAIL withdraw_done got done=%b err=%b exp 01/0", last_done, last_err); end
    repeat (10) @(negedge clk);
    checks++; if (start_cnt - s0 !== 1 || done_cnt - d0 !== 1) begin
      failures++; $display("FAIL withdraw_count got starts=%0d dones=%0d exp 1/1", start_cnt - s0, done_cnt - d0); end
    checks++; if (bus.rd_o !== 16'h00C3) begin failures++; $display("FAIL withdraw_rd got=%h exp=00C3", bus.rd_o); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    bus.spi_rd_l_i = 16'h0F0F;
    mdl_mode = 0; mdl_dly = 1; mdl_len = 40;
    @(negedge clk); bus.req_i = 2'b01;
    repeat (12) @(negedge clk);
    d0 = done_cnt;
    #2; rstn = 1'b0; bus.req_i = 2'b00;
    #1;
    checks++; if (bus.gnt_o !== 2'b00 || bus.spi_start_o !== 1'b0 || bus.done_o !== 2'b00) begin
      failures++; $display("FAIL rmid_ctl got gnt=%b start=%b done=%b exp 0", bus.gnt_o, bus.spi_start_o, bus.done_o); end
    checks++; if (bus.rd_o !== 16'h0000 || bus.err_sts_o !== 1'b0) begin
      failures++; $display("FAIL rmid_data got rd=%h sts=%b exp 0000/0", bus.rd_o, bus.err_sts_o); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL rmid_nodone got=%0d exp=%0d", done_cnt, d0); end
    bus.req_i = 2'b10;
    wait_done(d0 + 1, 300, ok);
    checks++; if (!ok || last_done !== 2'b10 || last_err !== 1'b0) begin
      failures++; $display("FAIL rmid_next got done=%b err=%b exp 10/0", last_done, last_err); end
    checks++; if (bus.gnt_o !== 2'b10 || bus.rd_o !== 16'h0F0F) begin
      failures++; $display("FAIL rmid_next_state got gnt=%b rd=%h exp 10/0F0F", bus.gnt_o, bus.rd_o); end
    bus.req_i = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rstn           = 1'b0;
    bus.req_i      = '0;
    bus.wr_h_i     = '0;
    bus.wr_l_i     = '0;
    bus.err_clr_i  = 1'b0;
    bus.spi_rd_l_i = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_bsy_timeout();
    test_xfer_timeout();
    test_withdraw();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
